// File: rtl/stdp_pkg.sv
// Shared constants and helpers for the STDP synapse array.
// Provides the default parameter values, the exponentially decaying step
// function and a saturating clamp. Both helpers work on int so callers can
// mix timer, weight and amplitude widths without sign surprises.
package stdp_pkg;

  localparam int N_DEF         = 4;
  localparam int TW_DEF        = 8;
  localparam int WW_DEF        = 8;
  localparam int W_INIT_DEF    = 64;
  localparam int W_MAX_DEF     = 255;
  localparam int W_MIN_DEF     = 0;
  localparam int A_PLUS_DEF    = 16;
  localparam int A_MINUS_DEF   = 8;
  localparam int TAU_SHIFT_DEF = 2;
  localparam int WINDOW_DEF    = 20;

  // Step for a spike distance dt >= 1: the amplitude halves every
  // 2^tau_shift cycles of dt. Callers only use the result when dt >= 1.
  function automatic int stdp_step(input int amp, input int dt, input int tau_shift);
    return amp >> ((dt - 1) >> tau_shift);
  endfunction

  // Saturate v into [lo, hi] instead of letting it wrap.
  function automatic int stdp_clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/stdp_channel.sv
// One pre-synaptic channel of the STDP array.
// Holds the pre-spike timer and seen flag, the weight register and the
// LTP/LTD decision for this channel.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   pre_spike       this channel's pre-synaptic spike pulse
//   post_spike      shared post-synaptic spike pulse
//   post_seen       a post spike has occurred since reset
//   post_t          cycles since the last post spike (saturating)
//   learn_en        allow learning updates
//   wr_en           host write already decoded for this channel
//   wr_data         host write value (clamped before storing)
//   weight          current weight
//   update_valid    one-cycle pulse when learning changed the weight
//   update_dir      1 = LTP, 0 = LTD, valid with update_valid
module stdp_channel
  import stdp_pkg::*;
#(
  parameter int TW        = TW_DEF,
  parameter int WW        = WW_DEF,
  parameter int W_INIT    = W_INIT_DEF,
  parameter int W_MAX     = W_MAX_DEF,
  parameter int W_MIN     = W_MIN_DEF,
  parameter int A_PLUS    = A_PLUS_DEF,
  parameter int A_MINUS   = A_MINUS_DEF,
  parameter int TAU_SHIFT = TAU_SHIFT_DEF,
  parameter int WINDOW    = WINDOW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pre_spike,
  input  logic          post_spike,
  input  logic          post_seen,
  input  logic [TW-1:0] post_t,
  input  logic          learn_en,
  input  logic          wr_en,
  input  logic [WW-1:0] wr_data,
  output logic [WW-1:0] weight,
  output logic          update_valid,
  output logic          update_dir
);

  logic [TW-1:0] pre_t_q, pre_t_d;
  logic          pre_seen_q, pre_seen_d;
  logic [WW-1:0] weight_q, weight_d;
  logic          update_valid_q, update_valid_d;
  logic          update_dir_q, update_dir_d;
  logic          ltp_hit, ltd_hit;

  // NOTE: every signal assigned in this block gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    pre_seen_d     = pre_seen_q | pre_spike;
    weight_d       = weight_q;
    update_valid_d = 1'b0;
    update_dir_d   = 1'b0;

    // Timer restarts at 1 on the cycle after a spike and saturates at all-ones.
    if (pre_spike)             pre_t_d = TW'(1);
    else if (pre_t_q != '1)    pre_t_d = pre_t_q + TW'(1);
    else                       pre_t_d = pre_t_q;

    // A coincident pre/post pair is neither LTP nor LTD.
    ltp_hit = learn_en && post_spike && !pre_spike && pre_seen_q &&
              (int'(pre_t_q) >= 1) && (int'(pre_t_q) <= WINDOW);
    ltd_hit = learn_en && pre_spike && !post_spike && post_seen &&
              (int'(post_t) >= 1) && (int'(post_t) <= WINDOW);

    // Host write wins over learning and suppresses the update pulse.
    if (wr_en) begin
      weight_d = WW'(stdp_clamp(int'(wr_data), W_MIN, W_MAX));
    end else if (ltp_hit) begin
      weight_d       = WW'(stdp_clamp(int'(weight_q) +
                                      stdp_step(A_PLUS, int'(pre_t_q), TAU_SHIFT),
                                      W_MIN, W_MAX));
      update_valid_d = 1'b1;
      update_dir_d   = 1'b1;
    end else if (ltd_hit) begin
      weight_d       = WW'(stdp_clamp(int'(weight_q) -
                                      stdp_step(A_MINUS, int'(post_t), TAU_SHIFT),
                                      W_MIN, W_MAX));
      update_valid_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  // NOTE: the weight register is reset along with the control state because
  // its reset value is architecturally visible (W_INIT), unlike a data RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_t_q        <= '0;
      pre_seen_q     <= 1'b0;
      weight_q       <= WW'(W_INIT);
      update_valid_q <= 1'b0;
      update_dir_q   <= 1'b0;
    end else begin
      pre_t_q        <= pre_t_d;
      pre_seen_q     <= pre_seen_d;
      weight_q       <= weight_d;
      update_valid_q <= update_valid_d;
      update_dir_q   <= update_dir_d;
    end
  end

  assign weight       = weight_q;
  assign update_valid = update_valid_q;
  assign update_dir   = update_dir_q;

endmodule

// File: rtl/stdp_synapse_array.sv
// STDP learning block for N synapses converging on one post-synaptic neuron.
// Owns the shared post-spike timer and seen flag plus the host write decode,
// and instantiates one stdp_channel per pre-synaptic input.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   pre_spike[N]    per-channel pre-synaptic spike pulses
//   post_spike      post-synaptic spike pulse
//   learn_en        allow learning updates
//   wr_en/wr_idx/wr_data  host weight write (wr_idx >= N ignored)
//   weight_flat     channel i at bits [i*WW +: WW]
//   update_valid[N] one-cycle pulse per channel on a learning update
//   update_dir[N]   1 = LTP, 0 = LTD
module stdp_synapse_array
  import stdp_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int TW        = TW_DEF,
  parameter int WW        = WW_DEF,
  parameter int W_INIT    = W_INIT_DEF,
  parameter int W_MAX     = W_MAX_DEF,
  parameter int W_MIN     = W_MIN_DEF,
  parameter int A_PLUS    = A_PLUS_DEF,
  parameter int A_MINUS   = A_MINUS_DEF,
  parameter int TAU_SHIFT = TAU_SHIFT_DEF,
  parameter int WINDOW    = WINDOW_DEF,
  localparam int IW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    pre_spike,
  input  logic            post_spike,
  input  logic            learn_en,
  input  logic            wr_en,
  input  logic [IW-1:0]   wr_idx,
  input  logic [WW-1:0]   wr_data,
  output logic [N*WW-1:0] weight_flat,
  output logic [N-1:0]    update_valid,
  output logic [N-1:0]    update_dir
);

  logic [TW-1:0] post_t_q, post_t_d;
  logic          post_seen_q, post_seen_d;
  logic [N-1:0]  wr_sel;

  always_comb begin
    post_seen_d = post_seen_q | post_spike;
    if (post_spike)          post_t_d = TW'(1);
    else if (post_t_q != '1) post_t_d = post_t_q + TW'(1);
    else                     post_t_d = post_t_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      post_t_q    <= '0;
      post_seen_q <= 1'b0;
    end else begin
      post_t_q    <= post_t_d;
      post_seen_q <= post_seen_d;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    // An out-of-range wr_idx matches no channel and is dropped here.
    assign wr_sel[i] = wr_en && (int'(wr_idx) == i);

    stdp_channel #(
      .TW(TW), .WW(WW), .W_INIT(W_INIT), .W_MAX(W_MAX), .W_MIN(W_MIN),
      .A_PLUS(A_PLUS), .A_MINUS(A_MINUS), .TAU_SHIFT(TAU_SHIFT), .WINDOW(WINDOW)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .pre_spike   (pre_spike[i]),
      .post_spike  (post_spike),
      .post_seen   (post_seen_q),
      .post_t      (post_t_q),
      .learn_en    (learn_en),
      .wr_en       (wr_sel[i]),
      .wr_data     (wr_data),
      .weight      (weight_flat[i*WW +: WW]),
      .update_valid(update_valid[i]),
      .update_dir  (update_dir[i])
    );
  end

endmodule

// File: tb/tb_stdp_synapse_array.sv
// Self-checking bench for stdp_synapse_array with default parameters.
// A driver applies one cycle of stimulus at a time, advances a reference
// model based on absolute spike times, and queues the expected outputs.
// A monitor pops one expectation per clock and compares it with the DUT.
module tb_stdp_synapse_array;

  localparam int N = 4;
  localparam int WW = 8;
  localparam int WINDOW = 20;
  localparam int TMAX = 255;

  logic            clk;
  logic            rst;
  logic [N-1:0]    pre_spike;
  logic            post_spike;
  logic            learn_en;
  logic            wr_en;
  logic [1:0]      wr_idx;
  logic [WW-1:0]   wr_data;
  logic [N*WW-1:0] weight_flat;
  logic [N-1:0]    update_valid;
  logic [N-1:0]    update_dir;

  stdp_synapse_array dut (
    .clk(clk), .rst(rst), .pre_spike(pre_spike), .post_spike(post_spike),
    .learn_en(learn_en), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .weight_flat(weight_flat), .update_valid(update_valid), .update_dir(update_dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N*WW-1:0] w;
    logic [N-1:0]    v;
    logic [N-1:0]    d;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: weights plus the absolute cycle of the last spikes.
  int m_t;
  int m_w[N];
  int m_pre_last[N];
  bit m_pre_seen[N];
  int m_post_last;
  bit m_post_seen;

  function automatic int dt_of(input int last);
    int d = m_t - last;
    return (d > TMAX) ? TMAX : d;
  endfunction

  function automatic int step_of(input int amp, input int dt);
    int halvings = (dt - 1) / 4;
    int s = amp;
    for (int k = 0; k < halvings; k++) s = s / 2;
    return s;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  task automatic model_step(input logic [N-1:0] pre, input logic post, input logic learn,
                            input logic wen, input int widx, input int wdata, input logic r);
    exp_t e;
    e.v = '0;
    e.d = '0;
    if (r) begin
      for (int i = 0; i < N; i++) begin
        m_w[i] = 64;
        m_pre_seen[i] = 0;
      end
      m_post_seen = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (wen && widx == i) begin
          m_w[i] = (wdata > 255) ? 255 : wdata;
        end else if (learn && post && !pre[i] && m_pre_seen[i] &&
                     dt_of(m_pre_last[i]) >= 1 && dt_of(m_pre_last[i]) <= WINDOW) begin
          m_w[i] = m_w[i] + step_of(16, dt_of(m_pre_last[i]));
          if (m_w[i] > 255) m_w[i] = 255;
          e.v[i] = 1'b1;
          e.d[i] = 1'b1;
        end else if (learn && pre[i] && !post && m_post_seen &&
                     dt_of(m_post_last) >= 1 && dt_of(m_post_last) <= WINDOW) begin
          m_w[i] = m_w[i] - step_of(8, dt_of(m_post_last));
          if (m_w[i] < 0) m_w[i] = 0;
          e.v[i] = 1'b1;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (pre[i]) begin
          m_pre_last[i] = m_t;
          m_pre_seen[i] = 1;
        end
      end
      if (post) begin
        m_post_last = m_t;
        m_post_seen = 1;
      end
    end
    for (int i = 0; i < N; i++) e.w[i*WW +: WW] = WW'(m_w[i]);
    exp_q.push_back(e);
    m_t++;
  endtask

  task automatic drive(input logic [N-1:0] pre, input logic post, input logic learn,
                       input logic wen, input int widx, input int wdata, input logic r);
    @(negedge clk);
    pre_spike  = pre;
    post_spike = post;
    learn_en   = learn;
    wr_en      = wen;
    wr_idx     = 2'(widx);
    wr_data    = WW'(wdata);
    rst        = r;
    model_step(pre, post, learn, wen, widx, wdata, r);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive('0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic pre_only(input logic [N-1:0] pre);
    drive(pre, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic post_only();
    drive('0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic host_write(input int idx, input int data);
    drive('0, 1'b0, 1'b1, 1'b1, idx, data, 1'b0);
  endtask

  // Monitor: one expectation per clock, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("weight_flat", 64'(weight_flat), 64'(e.w));
        check("update_valid", 64'(update_valid), 64'(e.v));
        check("update_dir", 64'(update_dir & update_valid), 64'(e.d));
      end
    end
  end

  initial begin
    int budget;
    m_t = 0;
    m_post_last = 0;
    m_post_seen = 0;
    for (int i = 0; i < N; i++) begin
      m_w[i] = 64;
      m_pre_last[i] = 0;
      m_pre_seen[i] = 0;
    end
    rst = 1'b1; pre_spike = '0; post_spike = 1'b0; learn_en = 1'b1;
    wr_en = 1'b0; wr_idx = '0; wr_data = '0;

    drive('0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b1);
    drive('0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b1);

    // First-ever post spike with no prior pre: no update anywhere.
    post_only(); idle(25);
    // LTP dt=3 on channel 0: 64 -> 80.
    pre_only(4'b0001); idle(2); post_only(); idle(25);
    // LTD dt=6 on channel 1: 64 -> 60.
    post_only(); idle(5); pre_only(4'b0010); idle(25);
    // dt=25 lies outside the window: no change.
    pre_only(4'b0100); idle(24); post_only(); idle(25);
    // Upper saturation: 250 + 16 -> 255.
    host_write(3, 250); pre_only(4'b1000); post_only(); idle(25);
    // Lower saturation: 3 - 8 -> 0.
    host_write(3, 3); post_only(); pre_only(4'b1000); idle(25);
    // Coincident pair gives nothing; the following post at dt=2 gives +16.
    drive(4'b0001, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0); idle(1); post_only(); idle(25);
    // Learning disabled during an LTP pair.
    pre_only(4'b0010); idle(1); drive('0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0); idle(25);
    // Reset in the middle of activity.
    pre_only(4'b1111); post_only();
    drive(4'b0101, 1'b0, 1'b1, 1'b1, 2, 9, 1'b1); idle(3);
    // Host write collides with LTP on channel 2: write wins, no pulse.
    pre_only(4'b0100); idle(1); drive('0, 1'b1, 1'b1, 1'b1, 2, 17, 1'b0); idle(25);

    // Randomised traffic.
    for (int k = 0; k < 3000; k++) begin
      logic [N-1:0] pre;
      for (int i = 0; i < N; i++) pre[i] = ($urandom_range(0, 5) == 0);
      drive(pre, ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 24) == 0), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 255)), ($urandom_range(0, 499) == 0));
    end
    drive('0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);

    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/stdp_synapse_array.md
Name: stdp_synapse_array

Overview:
- Parametrised STDP learning block for N synapses that converge on one post-synaptic neuron.
- Supports both potentiation (LTP, pre before post) and depression (LTD, post before pre).
- Step size decays exponentially with spike timing distance; weights saturate instead of wrapping.
- Sits between the spike generators and the neuron integrator. Weights are host-loadable and exposed as a flat bus.

Parameters:
- N, 4, number of pre-synaptic channels
- TW, 8, spike-timer width in bits
- WW, 8, weight width in bits
- W_INIT, 64, weight value after reset
- W_MAX, 255, upper saturation bound (must fit in WW bits)
- W_MIN, 0, lower saturation bound
- A_PLUS, 16, LTP step at dt=1
- A_MINUS, 8, LTD step at dt=1
- TAU_SHIFT, 2, step halves every 2^TAU_SHIFT cycles of dt
- WINDOW, 20, largest dt (in cycles) that causes an update; must be < 2^TW-1

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- pre_spike  in  N  per-channel pre-synaptic spike, one-cycle pulse
- post_spike  in  1  post-synaptic spike, one-cycle pulse
- learn_en  in  1  1 = weight updates allowed
- wr_en  in  1  host weight write strobe
- wr_idx  in  clog2(N)  channel selected for the write
- wr_data  in  WW  weight value to write
- weight_flat  out  N*WW  channel i occupies bits [i*WW +: WW]
- update_valid  out  N  one-cycle pulse per channel when its weight changed by learning
- update_dir  out  N  1 = LTP, 0 = LTD; meaningful only where update_valid is set

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is synchronous and active-high. All state is sampled on the rising edge of clk.
- Reset values:
  - weights = W_INIT
  - all timers = 0
  - pre_seen and post_seen flags = 0
  - update_valid = 0, update_dir = 0
- Reset asserted mid-operation overrides everything on the next edge, including wr_en.
- Timers:
  - pre_t[i] loads 1 on the cycle after pre_spike[i], then increments by 1 per cycle, saturating at 2^TW-1.
  - post_t behaves the same way for post_spike.
  - A spike also sets its seen flag, which stays set until rst.
  - The timer value at cycle t is the dt since the last spike, in cycles.
- LTP, channel i, cycle t:
  - Condition: post_spike=1, pre_spike[i]=0, pre_seen[i]=1, 1 <= pre_t[i] <= WINDOW, learn_en=1.
  - Action: weight += A_PLUS >> ((pre_t[i]-1) >> TAU_SHIFT).
- LTD, channel i, cycle t:
  - Condition: pre_spike[i]=1, post_spike=0, post_seen=1, 1 <= post_t <= WINDOW, learn_en=1.
  - Action: weight -= A_MINUS >> ((post_t-1) >> TAU_SHIFT).
- Arithmetic:
  - Compute in WW+1 bits, then clamp to [W_MIN, W_MAX].
  - A step that shifts to 0 still asserts update_valid; the weight is unchanged.
- Simultaneous pre_spike[i] and post_spike: no update for channel i. Both timers still restart.
- learn_en=0: timers and flags still run; weights are frozen; update_valid stays 0.
- Latency:
  - A learning update is visible on weight_flat and update_valid at t+1.
  - update_valid is high for exactly one cycle per qualifying spike.
- Host write:
  - wr_en=1 at cycle t sets weight[wr_idx]=wr_data at t+1.
  - wr_data is clamped to [W_MIN, W_MAX].
  - A write beats a learning update to the same channel in the same cycle; that channel gets no update_valid.
  - A wr_idx >= N is ignored.
- Channels are independent. One post spike may update all N channels in the same cycle.

Decomposition:
- Package stdp_pkg holds:
  - default parameter constants
  - a step function: amplitude, dt and tau_shift in, shifted step out
  - a clamp helper
- Sub-module stdp_channel holds one channel's pre timer, seen flag, weight register and LTP/LTD logic.
- It is instantiated N times in a generate loop.
- The top level owns the shared post timer, post_seen flag and write decode.

Test Plan (default parameters):
- pre_spike[0] at cycle 10, post_spike at 13 (dt=3) -> at cycle 14 weight0 = 64 -> 80, update_valid = 4'b0001, update_dir[0]=1; channels 1-3 stay 64.
- post_spike at 10, pre_spike[1] at 16 (dt=6, step 8>>1=4) -> weight1 = 60 at cycle 17, update_dir[1]=0.
- pre_spike[2] at 0, post_spike at 25 (dt=25 > WINDOW) -> no change, update_valid stays 0. A first-ever post_spike with no prior pre also gives no update.
- Saturation:
  - Write weight3=250, then pre[3] and post 1 cycle apart -> weight3=255, not 10.
  - Write weight3=3, then LTD at dt=1 -> weight3=0.
- pre_spike[0] and post_spike in the same cycle -> no update. A second post_spike 2 cycles later (dt=2) -> weight0 +16.
- learn_en=0 during an LTP pair -> no change. rst asserted mid-run -> next cycle all weights 64 and update_valid=0. wr_en together with LTP on the same channel -> wr_data wins.
